// File: rtl/select_max_stream.sv
// select_max_stream: snapshot NEURON_NB signed values on start, scan LANES per cycle, report argmax, max and margin
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start                begin a classification (accepted only when idle)
//   in_data              NEURON_NB packed signed elements, element k at [k*DATA_W +: DATA_W]
//   busy / done / valid  scanning / one-cycle result pulse / results hold a classification
//   digit, max_val       index and value of the winning element
//   margin               winner minus runner-up, unsigned DATA_W+1 bits
module select_max_stream #(
  parameter int NEURON_NB = 10,
  parameter int DATA_W = 16,
  parameter int LANES = 1,
  parameter int TIE_LAST = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NEURON_NB*DATA_W-1:0]   in_data,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic [((NEURON_NB > 1) ? $clog2(NEURON_NB) : 1)-1:0] digit,
  output logic signed [DATA_W-1:0]      max_val,
  output logic [DATA_W:0]               margin
);
  localparam int IDX_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
  localparam int G = (NEURON_NB + LANES - 1) / LANES;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic signed [DATA_W-1:0] snap [NEURON_NB];
  logic [IDX_W-1:0] g_cnt, best_idx, nb_i;
  logic signed [DATA_W-1:0] best_val, sec_val, nb_v, ns_v, v;
  logic best_seen, sec_seen, nb_s, ns_s;
  logic [DATA_W:0] nx_margin;
  int k;
  // Lanes of the current group folded in index order, so a group behaves like LANES sequential steps.
  always_comb begin
    nb_v = best_val;
    nb_i = best_idx;
    nb_s = best_seen;
    ns_v = sec_val;
    ns_s = sec_seen;
    k = 0;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      k = int'(g_cnt) * LANES + l;
      v = snap[IDX_W'(k)];
      if (k < NEURON_NB) begin
        if (!nb_s || v > nb_v || (TIE_LAST != 0 && v == nb_v)) begin
          ns_v = nb_v;
          ns_s = nb_s;
          nb_v = v;
          nb_i = IDX_W'(k);
          nb_s = 1'b1;
        end else if (!ns_s || v > ns_v) begin
          ns_v = v;
          ns_s = 1'b1;
        end
      end
    end
    nx_margin = ns_s ? {nb_v[DATA_W-1], nb_v} - {ns_v[DATA_W-1], ns_v} : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      valid <= 1'b0;
      digit <= '0;
      max_val <= '0;
      margin <= '0;
      g_cnt <= '0;
      best_idx <= '0;
      best_val <= '0;
      sec_val <= '0;
      best_seen <= 1'b0;
      sec_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          for (int i = 0; i < NEURON_NB; i++) snap[i] <= in_data[i*DATA_W +: DATA_W];
          g_cnt <= '0;
          best_seen <= 1'b0;
          sec_seen <= 1'b0;
          valid <= 1'b0;
          busy <= 1'b1;
          state <= SCAN;
        end
      end else begin
        best_val <= nb_v;
        best_idx <= nb_i;
        best_seen <= nb_s;
        sec_val <= ns_v;
        sec_seen <= ns_s;
        g_cnt <= g_cnt + IDX_W'(1);
        if (g_cnt == IDX_W'(G - 1)) begin
          digit <= nb_i;
          max_val <= nb_v;
          margin <= nx_margin;
          done <= 1'b1;
          valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule
